hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the IF/ID and ID/EX pipeline registers of the 5-stage RISC-V core. It watches the opcode and register fields decoded out of IF/ID, plus the load, destination and branch status of the later stages. From these it drives the write-enables, flush and bubble controls that stall or squash the front end. It resolves load-use hazards, taken-branch flushes and external data-memory holds, with a fixed priority.

---
 rtl/rv_pkg.sv | 18 +
 rtl/hazard_detect.sv | 43 ++++
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared core definitions: opcode constants, NOP encoding, hazard FSM states.
package rv_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detection on the IF/ID source registers.
// Shared with the forwarding unit; holds no state.
module hazard_detect
    import rv_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       mem_read_i,
    input  logic [4:0] rd_i,
    output logic       load_use_o
);

    logic uses_rs1;
    logic uses_rs2;

    // Unknown opcodes read no registers, so they can never stall.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        unique case (1'b1)
            (opcode_i == OP_R),
            (opcode_i == OP_ST),
            (opcode_i == OP_BR): begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            (opcode_i == OP_I),
            (opcode_i == OP_LD): begin
                uses_rs1 = 1'b1;
            end
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

    assign load_use_o = mem_read_i && (rd_i != 5'd0)
                     && ((uses_rs1 && (rd_i == rs1_i))
                      || (uses_rs2 && (rd_i == rs2_i)));

endmodule

// File: rtl/hazard_ctrl.sv
// Front-end stall/flush/hold sequencer for IF/ID and ID/EX.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned BRANCH_PENALTY = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       if_id_opcode,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pc_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] FCNT_INIT = 2'(BRANCH_PENALTY - 1);

    hz_state_e  state_q, state_d;
    logic [1:0] fcnt_q, fcnt_d;
    logic       load_use;

    hazard_detect u_detect (
        .opcode_i   (if_id_opcode),
        .rs1_i      (if_id_rs1),
        .rs2_i      (if_id_rs2),
        .mem_read_i (id_ex_mem_read),
        .rd_i       (id_ex_rd),
        .load_use_o (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            fcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (dmem_busy) begin
                    state_d = ST_HOLD;
                end else if (ex_branch_taken && (BRANCH_PENALTY > 1)) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FCNT_INIT;
                end
            end
            ST_FLUSH: begin
                // A memory hold freezes the remaining flush count.
                if (!dmem_busy) begin
                    fcnt_d = fcnt_q - 2'd1;
                    if (fcnt_q == 2'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_HOLD: begin
                if (!dmem_busy) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = 2'd0;
            end
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pc_sel       = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (dmem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                end else if (ex_branch_taken) begin
                    pc_sel       = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (dmem_busy) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                end else begin
                    if_id_flush = 1'b1;
                end
            end
            ST_HOLD: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end
            default: begin
                pc_write = 1'b1;
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic             stall_cyc;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign stall_cyc = (state_q == ST_RUN) && !dmem_busy
                    && !ex_branch_taken && load_use;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_cyc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (if_id_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (BRANCH_PENALTY=2, CNT_W=3).
// Counter expectations follow whether HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;
    import rv_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [4:0] NORM  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00010;
    localparam logic [4:0] BRAN  = 5'b11111;
    localparam logic [4:0] FLSH  = 5'b11100;
    localparam logic [4:0] HOLD  = 5'b00000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       mem_read, br_taken, busy;
    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, pc_sel;
    logic [2:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [12];

    hazard_ctrl #(.BRANCH_PENALTY(2), .CNT_W(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_id_opcode    (opcode),
        .if_id_rs1       (rs1),
        .if_id_rs2       (rs2),
        .id_ex_mem_read  (mem_read),
        .id_ex_rd        (rd),
        .ex_branch_taken (br_taken),
        .dmem_busy       (busy),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .pc_sel          (pc_sel),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string name, input logic [4:0] exp);
        chk(name, {27'd0, pc_write, if_id_write, if_id_flush,
                   id_ex_bubble, pc_sel}, {27'd0, exp});
    endtask

    task automatic chk_cnt(input string name, input int s, input int f);
        chk({name, "_stall_cnt"}, {29'd0, stall_cnt}, PERF ? s : 0);
        chk({name, "_flush_cnt"}, {29'd0, flush_cnt}, PERF ? f : 0);
    endtask

    task automatic idle();
        opcode   = OP_R;
        rs1      = 5'd1;
        rs2      = 5'd2;
        rd       = 5'd3;
        mem_read = 1'b0;
        br_taken = 1'b0;
        busy     = 1'b0;
    endtask

    task automatic lu();
        idle();
        rs1      = 5'd5;
        rd       = 5'd5;
        mem_read = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        vecs[0]  = '{OP_R,  5'd1, 5'd2, 1'b0, 5'd3, NORM};
        vecs[1]  = '{OP_R,  5'd5, 5'd2, 1'b1, 5'd5, STALL};
        vecs[2]  = '{OP_R,  5'd1, 5'd5, 1'b1, 5'd5, STALL};
        vecs[3]  = '{OP_R,  5'd0, 5'd0, 1'b1, 5'd0, NORM};
        vecs[4]  = '{OP_I,  5'd1, 5'd5, 1'b1, 5'd5, NORM};
        vecs[5]  = '{OP_I,  5'd5, 5'd2, 1'b1, 5'd5, STALL};
        vecs[6]  = '{OP_ST, 5'd1, 5'd5, 1'b1, 5'd5, STALL};
        vecs[7]  = '{OP_BR, 5'd1, 5'd5, 1'b1, 5'd5, STALL};
        vecs[8]  = '{OP_LD, 5'd5, 5'd2, 1'b1, 5'd5, STALL};
        vecs[9]  = '{OP_LD, 5'd1, 5'd5, 1'b1, 5'd5, NORM};
        vecs[10] = '{7'h7f, 5'd5, 5'd5, 1'b1, 5'd5, NORM};
        vecs[11] = '{OP_R,  5'd5, 5'd5, 1'b0, 5'd5, NORM};

        idle();
        rst_n = 1'b0;
        #2;
        chk_ctl("reset_outputs", NORM);
        chk_cnt("reset", 0, 0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            idle();
            opcode   = vecs[i].op;
            rs1      = vecs[i].rs1;
            rs2      = vecs[i].rs2;
            mem_read = vecs[i].mr;
            rd       = vecs[i].rd;
            #2;
            chk_ctl($sformatf("vec%0d", i), vecs[i].exp);
            step();
        end
        idle();
        #2;
        chk_cnt("after_table", 6, 0);

        do_reset();
        lu();
        #2;
        chk_ctl("lu_stall", STALL);
        chk_cnt("lu_stall", 0, 0);
        step();
        mem_read = 1'b0;
        #2;
        chk_ctl("lu_cleared", NORM);
        chk_cnt("lu_cleared", 1, 0);
        step();

        lu();
        br_taken = 1'b1;
        #2;
        chk_ctl("br_over_lu", BRAN);
        step();
        br_taken = 1'b0;
        #2;
        chk_ctl("br_flush2", FLSH);
        chk_cnt("br_flush2", 1, 1);
        step();
        idle();
        #2;
        chk_ctl("br_done", NORM);
        chk_cnt("br_done", 1, 2);
        step();

        br_taken = 1'b1;
        #2;
        chk_ctl("hf_branch", BRAN);
        step();
        br_taken = 1'b0;
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk_ctl($sformatf("hf_hold%0d", i), HOLD);
            step();
        end
        busy = 1'b0;
        #2;
        chk_ctl("hf_resume", FLSH);
        chk_cnt("hf_resume", 1, 3);
        step();
        #2;
        chk_ctl("hf_run", NORM);
        chk_cnt("hf_run", 1, 4);
        step();

        busy = 1'b1;
        #2;
        chk_ctl("hold_enter", HOLD);
        step();
        #2;
        chk_ctl("hold_busy", HOLD);
        step();
        busy = 1'b0;
        br_taken = 1'b1;
        #2;
        chk_ctl("hold_release", HOLD);
        step();
        #2;
        chk_ctl("hold_br_replay", BRAN);
        step();
        br_taken = 1'b0;
        #2;
        chk_ctl("hold_br_flush", FLSH);
        step();
        #2;
        chk_ctl("hold_br_done", NORM);
        chk_cnt("hold_br_done", 1, 6);
        step();

        br_taken = 1'b1;
        #2;
        chk_ctl("rst_branch", BRAN);
        step();
        br_taken = 1'b0;
        #2;
        chk_ctl("rst_in_flush", FLSH);
        rst_n = 1'b0;
        #1;
        chk_ctl("rst_async", NORM);
        chk_cnt("rst_async", 0, 0);
        #1;
        rst_n = 1'b1;
        step();
        #2;
        chk_ctl("rst_run", NORM);
        step();
        lu();
        #2;
        chk_ctl("rst_lu", STALL);
        step();

        for (int i = 0; i < 9; i++) begin
            #2;
            chk_ctl($sformatf("sat_stall%0d", i), STALL);
            step();
        end
        idle();
        #2;
        chk_cnt("saturate", 7, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
